// File: rtl/event_counter_pkg.sv
// -----------------------------------------------------------------------------
// event_counter_pkg
// Shared definitions for the event counter bank:
//   ch_w()            - width of a channel index (minimum 1 bit)
//   DIV_INIT_DEFAULT  - reset divide ratio for channels 1..NCH-1
//   count_lsb()       - LSB position of a channel's slice in the packed Count bus
// -----------------------------------------------------------------------------
package event_counter_pkg;

  localparam int DIV_INIT_DEFAULT = 3;

  // A single-channel or two-channel bank still needs a 1-bit select port.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Channel c occupies Count[c*width +: width].
  function automatic int count_lsb(input int c, input int width);
    return c * width;
  endfunction

endpackage

// File: rtl/event_counter_chan.sv
// -----------------------------------------------------------------------------
// event_counter_chan
// One channel of the event counter bank: divide-ratio register, prescaler,
// counter, sticky overflow flag and increment strobe.
//
// Ports:
//   Clk      in   clock, rising edge
//   Reset_n  in   asynchronous active-low reset
//   ev       in   qualified event steered to this channel
//   clr      in   synchronous clear (Cnt, Pre, Ovf, Tick; Div kept)
//   cfg_we   in   divide-ratio write for this channel
//   cfg_div  in   new divide ratio
//   cnt      out  counter value
//   ovf      out  sticky overflow flag
//   tick     out  one-cycle pulse when cnt incremented
//
// Build option: SATURATE_EN - counter holds at all-ones instead of wrapping.
// -----------------------------------------------------------------------------
module event_counter_chan #(
  parameter int WIDTH   = 64,
  parameter int PRE_W   = 4,
  parameter int DIV_RST = 0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             ev,
  input  logic             clr,
  input  logic             cfg_we,
  input  logic [PRE_W-1:0] cfg_div,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf,
  output logic             tick
);

  logic [PRE_W-1:0] div;
  logic [PRE_W-1:0] pre;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; later assignments to pre in this block
  // override earlier ones, which gives clear+config both taking effect.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div  <= PRE_W'(DIV_RST);
      pre  <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (clr) begin
        cnt <= '0;
        pre <= '0;
        ovf <= 1'b0;
      end
      if (cfg_we) begin
        div <= cfg_div;
        pre <= '0;
      end
      // Clear and configuration both drop a coincident event.
      if (ev && !clr && !cfg_we) begin
        if (pre == div) begin
          pre <= '0;
`ifdef SATURATE_EN
          if (&cnt) begin
            ovf <= 1'b1;
          end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b1;
          end
`else
          cnt  <= cnt + 1'b1;
          tick <= 1'b1;
          if (&cnt) ovf <= 1'b1;
`endif
        end else begin
          pre <= pre + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/event_counter_bank.sv
// -----------------------------------------------------------------------------
// event_counter_bank
// Bank of NCH independent prescaled event counters used as a performance /
// event monitor. An event (En=1) is steered to channel Slt; out-of-range
// selects are ignored.
//
// Ports:
//   Clk      in   clock, rising edge
//   Reset_n  in   asynchronous active-low reset
//   En       in   event qualifier
//   Slt      in   channel receiving the event
//   Clr      in   per-channel synchronous clear mask
//   Cfg_we   in   divide-ratio write strobe
//   Cfg_ch   in   channel written
//   Cfg_div  in   new divide ratio (effective ratio Cfg_div+1)
//   Count    out  packed counters, channel c at [c*WIDTH +: WIDTH]
//   Ovf      out  sticky overflow per channel
//   Tick     out  one-cycle increment pulse per channel
//
// Build option: SATURATE_EN - counters saturate instead of wrapping.
// -----------------------------------------------------------------------------
module event_counter_bank
  import event_counter_pkg::*;
#(
  parameter  int WIDTH    = 64,
  parameter  int NCH      = 2,
  parameter  int PRE_W    = 4,
  parameter  int DIV_INIT = DIV_INIT_DEFAULT,
  localparam int SW       = ch_w(NCH)
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 En,
  input  logic [SW-1:0]        Slt,
  input  logic [NCH-1:0]       Clr,
  input  logic                 Cfg_we,
  input  logic [SW-1:0]        Cfg_ch,
  input  logic [PRE_W-1:0]     Cfg_div,
  output logic [NCH*WIDTH-1:0] Count,
  output logic [NCH-1:0]       Ovf,
  output logic [NCH-1:0]       Tick
);

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    logic             ev;
    logic             cfg_hit;
    logic [WIDTH-1:0] cnt;

    // Selects >= NCH match no channel, so those events vanish here.
    assign ev      = En && (Slt == SW'(c));
    assign cfg_hit = Cfg_we && (Cfg_ch == SW'(c));

    event_counter_chan #(
      .WIDTH   (WIDTH),
      .PRE_W   (PRE_W),
      .DIV_RST ((c == 0) ? 0 : DIV_INIT)
    ) u_chan (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .ev      (ev),
      .clr     (Clr[c]),
      .cfg_we  (cfg_hit),
      .cfg_div (Cfg_div),
      .cnt     (cnt),
      .ovf     (Ovf[c]),
      .tick    (Tick[c])
    );

    assign Count[count_lsb(c, WIDTH) +: WIDTH] = cnt;
  end

endmodule

// File: tb/tb_event_counter_bank.sv
module tb_event_counter_bank;

  localparam int W    = 4;
  localparam int N    = 3;
  localparam int PW   = 4;
  localparam int DI   = 3;
  localparam int CMAX = (1 << W) - 1;
`ifdef SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic           Clk = 1'b0;
  logic           Reset_n;
  logic           En;
  logic [1:0]     Slt;
  logic [N-1:0]   Clr;
  logic           Cfg_we;
  logic [1:0]     Cfg_ch;
  logic [PW-1:0]  Cfg_div;
  logic [N*W-1:0] Count;
  logic [N-1:0]   Ovf;
  logic [N-1:0]   Tick;

  int checks   = 0;
  int failures = 0;

  // Reference state, plain integers per channel.
  int m_div [N];
  int m_pre [N];
  int m_cnt [N];
  bit m_ovf [N];
  bit m_tick[N];

  always #5 Clk = ~Clk;

  event_counter_bank #(
    .WIDTH    (W),
    .NCH      (N),
    .PRE_W    (PW),
    .DIV_INIT (DI)
  ) u_dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .En      (En),
    .Slt     (Slt),
    .Clr     (Clr),
    .Cfg_we  (Cfg_we),
    .Cfg_ch  (Cfg_ch),
    .Cfg_div (Cfg_div),
    .Count   (Count),
    .Ovf     (Ovf),
    .Tick    (Tick)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_div[c]  = (c == 0) ? 0 : DI;
      m_pre[c]  = 0;
      m_cnt[c]  = 0;
      m_ovf[c]  = 1'b0;
      m_tick[c] = 1'b0;
    end
  endtask

  // Prescaler is an event tally modulo (Div+1); a tally returning to zero
  // is one counted event.
  task automatic model_step(input bit en, input int slt, input bit [N-1:0] clr,
                            input bit we, input int ch, input int dv);
    for (int c = 0; c < N; c++) begin
      bit cfg_hit;
      cfg_hit   = we && (ch == c);
      m_tick[c] = 1'b0;
      if (clr[c]) begin
        m_cnt[c] = 0;
        m_pre[c] = 0;
        m_ovf[c] = 1'b0;
      end
      if (cfg_hit) begin
        m_div[c] = dv;
        m_pre[c] = 0;
      end
      if (en && slt == c && !clr[c] && !cfg_hit) begin
        m_pre[c] = (m_pre[c] + 1) % (m_div[c] + 1);
        if (m_pre[c] == 0) begin
          if (m_cnt[c] == CMAX) m_ovf[c] = 1'b1;
          if (!(SAT && m_cnt[c] == CMAX)) begin
            m_tick[c] = 1'b1;
            m_cnt[c]  = (m_cnt[c] + 1) % (CMAX + 1);
          end
        end
      end
    end
  endtask

  function automatic logic [N*W-1:0] m_count();
    logic [N*W-1:0] v = '0;
    for (int c = 0; c < N; c++) v[c*W +: W] = W'(m_cnt[c]);
    return v;
  endfunction

  function automatic logic [N-1:0] m_flags(input bit sel_tick);
    logic [N-1:0] v = '0;
    for (int c = 0; c < N; c++) v[c] = sel_tick ? m_tick[c] : m_ovf[c];
    return v;
  endfunction

  function automatic logic [W-1:0] dut_cnt(input int c);
    return Count[c*W +: W];
  endfunction

  task automatic compare_all();
    check("count", 64'(Count), 64'(m_count()));
    check("ovf",   64'(Ovf),   64'(m_flags(1'b0)));
    check("tick",  64'(Tick),  64'(m_flags(1'b1)));
  endtask

  // One clock: drive, advance model at the edge, compare 1 time unit later.
  task automatic cycle(input bit en, input int slt, input bit [N-1:0] clr,
                       input bit we, input int ch, input int dv);
    En      = en;
    Slt     = 2'(slt);
    Clr     = clr;
    Cfg_we  = we;
    Cfg_ch  = 2'(ch);
    Cfg_div = PW'(dv);
    @(posedge Clk);
    model_step(en, slt, clr, we, ch, dv);
    #1;
    compare_all();
  endtask

  task automatic ev(input int ch);
    cycle(1'b1, ch, '0, 1'b0, 0, 0);
  endtask

  task automatic clr_ch(input int ch);
    cycle(1'b0, 0, N'(1 << ch), 1'b0, 0, 0);
  endtask

  initial begin
    logic [N*W-1:0] snap;

    Reset_n = 1'b0;
    En = 1'b0; Slt = '0; Clr = '0; Cfg_we = 1'b0; Cfg_ch = '0; Cfg_div = '0;
    model_reset();
    #12;
    check("rst_count", 64'(Count), 64'd0);
    check("rst_ovf",   64'(Ovf),   64'd0);
    check("rst_tick",  64'(Tick),  64'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Reset divide ratios: ch0 every event, ch1 every 4th.
    for (int i = 0; i < 8; i++) ev(0);
    check("dflt_cnt0", 64'(dut_cnt(0)), 64'd8);
    for (int i = 1; i <= 8; i++) begin
      ev(1);
      check("dflt_tick1", 64'(Tick[1]), 64'((i % 4) == 0));
    end
    check("dflt_cnt1", 64'(dut_cnt(1)), 64'd2);

    // Reconfigure discards the partial prescale.
    clr_ch(1);
    ev(1); ev(1);
    cycle(1'b0, 0, '0, 1'b1, 1, 0);
    for (int i = 0; i < 3; i++) ev(1);
    check("recfg_cnt1", 64'(dut_cnt(1)), 64'd3);

    // Priority: clear + config + event together.
    clr_ch(0);
    for (int i = 0; i < 5; i++) ev(0);
    check("prio_pre", 64'(dut_cnt(0)), 64'd5);
    cycle(1'b1, 0, 3'b001, 1'b1, 0, 1);
    check("prio_clr", 64'(dut_cnt(0)), 64'd0);
    ev(0); ev(0);
    check("prio_div1", 64'(dut_cnt(0)), 64'd1);
    cycle(1'b0, 0, '0, 1'b1, 0, 0);
    cycle(1'b1, 0, 3'b010, 1'b0, 0, 0);
    check("prio_other", 64'(dut_cnt(0)), 64'd2);
    check("prio_clr1",  64'(dut_cnt(1)), 64'd0);

    // Wrap / saturate at the top of a 4-bit counter.
    clr_ch(0);
    for (int i = 0; i < 15; i++) ev(0);
    check("wrap_15",  64'(dut_cnt(0)), 64'd15);
    check("wrap_novf", 64'(Ovf[0]), 64'd0);
    ev(0);
    check("wrap_cnt",  64'(dut_cnt(0)), SAT ? 64'd15 : 64'd0);
    check("wrap_ovf",  64'(Ovf[0]), 64'd1);
    check("wrap_tick", 64'(Tick[0]), SAT ? 64'd0 : 64'd1);
    ev(0);
    check("wrap_sticky", 64'(Ovf[0]), 64'd1);

    // Asynchronous reset between edges.
    clr_ch(0);
    for (int i = 0; i < 7; i++) ev(0);
    check("mid_pre", 64'(dut_cnt(0)), 64'd7);
    En = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check("mid_cnt0", 64'(dut_cnt(0)), 64'd0);
    check("mid_all",  64'(Count), 64'd0);
    check("mid_ovf",  64'(Ovf), 64'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Out-of-range select leaves every channel untouched.
    ev(0); ev(0); ev(2); ev(2); ev(2); ev(2);
    snap = m_count();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 3, '0, 1'b0, 0, 0);
      check("oor_hold", 64'(Count), 64'(snap));
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      bit         r_en  = 1'($urandom_range(0, 3) != 0);
      int         r_slt = $urandom_range(0, 3);
      bit [N-1:0] r_clr = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
      bit         r_we  = ($urandom_range(0, 11) == 0);
      int         r_ch  = $urandom_range(0, 3);
      int         r_dv  = $urandom_range(0, 2);
      cycle(r_en, r_slt, r_clr, r_we, r_ch, r_dv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
